// File: rtl/csr_reg_pkg.sv
// ---------------------------------------------------------------------------
// csr_reg_pkg
// Shared definitions for the machine-mode CSR register file: 12-bit CSR
// addresses, the misa constant, per-register write masks, and a decoder that
// maps an address onto a compact register select used by the read mux and
// the write logic.
// ---------------------------------------------------------------------------
package csr_reg_pkg;

  // Trap/status registers
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;

  // Writable machine counters
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // Read-only user mirrors and id
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // RV32 (MXL=1) with the I extension
  localparam logic [31:0] CSR_MISA_VAL      = 32'h4000_0100;
  // mstatus keeps only SINT (31), MPIE (7) and MIE (3)
  localparam logic [31:0] CSR_MSTATUS_WMASK = 32'h8000_0088;
  // mepc is always word aligned
  localparam logic [31:0] CSR_MEPC_WMASK    = 32'hFFFF_FFFC;

  typedef enum logic [4:0] {
    SEL_NONE,
    SEL_MSTATUS,
    SEL_MISA,
    SEL_MIE,
    SEL_MTVEC,
    SEL_MSCRATCH,
    SEL_MEPC,
    SEL_MCAUSE,
    SEL_MCYCLE,
    SEL_MCYCLEH,
    SEL_MINSTRET,
    SEL_MINSTRETH,
    SEL_CYCLE,
    SEL_CYCLEH,
    SEL_INSTRET,
    SEL_INSTRETH,
    SEL_MHARTID
  } csr_sel_e;

  function automatic csr_sel_e csr_decode(input logic [11:0] addr);
    csr_sel_e sel;
    case (addr)
      CSR_MSTATUS:   sel = SEL_MSTATUS;
      CSR_MISA:      sel = SEL_MISA;
      CSR_MIE:       sel = SEL_MIE;
      CSR_MTVEC:     sel = SEL_MTVEC;
      CSR_MSCRATCH:  sel = SEL_MSCRATCH;
      CSR_MEPC:      sel = SEL_MEPC;
      CSR_MCAUSE:    sel = SEL_MCAUSE;
      CSR_MCYCLE:    sel = SEL_MCYCLE;
      CSR_MCYCLEH:   sel = SEL_MCYCLEH;
      CSR_MINSTRET:  sel = SEL_MINSTRET;
      CSR_MINSTRETH: sel = SEL_MINSTRETH;
      CSR_CYCLE:     sel = SEL_CYCLE;
      CSR_CYCLEH:    sel = SEL_CYCLEH;
      CSR_INSTRET:   sel = SEL_INSTRET;
      CSR_INSTRETH:  sel = SEL_INSTRETH;
      CSR_MHARTID:   sel = SEL_MHARTID;
      default:       sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // Bits a write may store. Read-only and unmapped selects get an all-zero
  // mask, which is what makes writes to them vanish.
  function automatic logic [31:0] csr_wmask(input csr_sel_e sel);
    logic [31:0] m;
    case (sel)
      SEL_MSTATUS:   m = CSR_MSTATUS_WMASK;
      SEL_MEPC:      m = CSR_MEPC_WMASK;
      SEL_MIE,
      SEL_MTVEC,
      SEL_MSCRATCH,
      SEL_MCAUSE,
      SEL_MCYCLE,
      SEL_MCYCLEH,
      SEL_MINSTRET,
      SEL_MINSTRETH: m = 32'hFFFF_FFFF;
      default:       m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  function automatic logic csr_writable(input csr_sel_e sel);
    return (sel == SEL_MSTATUS)  || (sel == SEL_MIE)      ||
           (sel == SEL_MTVEC)    || (sel == SEL_MSCRATCH) ||
           (sel == SEL_MEPC)     || (sel == SEL_MCAUSE)   ||
           (sel == SEL_MCYCLE)   || (sel == SEL_MCYCLEH)  ||
           (sel == SEL_MINSTRET) || (sel == SEL_MINSTRETH);
  endfunction

endpackage

// File: rtl/csr_reg_if.sv
// ---------------------------------------------------------------------------
// csr_reg_if
// Bus bundle between the core (decode/execute + clint trap sequencer) and the
// CSR register file.
//   ex_csr_raddr_i        read address (combinational read)
//   ex_csr_rdata_o        read data
//   ex_csr_waddr_i/_vld_i/ex_csr_wdata_i        execute-stage write port
//   clint_csr_waddr_i/_vld_i/clint_csr_wdata_i  clint write port
// master: core side, slave: csr_reg.
// ---------------------------------------------------------------------------
interface csr_reg_if #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int CSR_BUS_WIDTH  = 32
);

  logic [CSR_BUS_WIDTH-1:0]  ex_csr_raddr_i;
  logic [DATA_BUS_WIDTH-1:0] ex_csr_rdata_o;

  logic [CSR_BUS_WIDTH-1:0]  ex_csr_waddr_i;
  logic                      ex_csr_waddr_vld_i;
  logic [DATA_BUS_WIDTH-1:0] ex_csr_wdata_i;

  logic [CSR_BUS_WIDTH-1:0]  clint_csr_waddr_i;
  logic                      clint_csr_waddr_vld_i;
  logic [DATA_BUS_WIDTH-1:0] clint_csr_wdata_i;

  modport master (
    output ex_csr_raddr_i,
    input  ex_csr_rdata_o,
    output ex_csr_waddr_i,
    output ex_csr_waddr_vld_i,
    output ex_csr_wdata_i,
    output clint_csr_waddr_i,
    output clint_csr_waddr_vld_i,
    output clint_csr_wdata_i
  );

  modport slave (
    input  ex_csr_raddr_i,
    output ex_csr_rdata_o,
    input  ex_csr_waddr_i,
    input  ex_csr_waddr_vld_i,
    input  ex_csr_wdata_i,
    input  clint_csr_waddr_i,
    input  clint_csr_waddr_vld_i,
    input  clint_csr_wdata_i
  );

endinterface

// File: rtl/csr_counter64.sv
// ---------------------------------------------------------------------------
// csr_counter64
// 64-bit counter (two HALF_W halves) with increment enable and independent
// low/high half writes. A write to either half suppresses the increment for
// that cycle; unwritten halves keep their value.
//   clk_i, rst_n_i   clock, async active-low reset
//   inc_i            count this cycle
//   wr_lo_i/wr_hi_i  write the low/high half
//   wdata_lo_i/_hi_i data for each half
//   cnt_o            current count
// ---------------------------------------------------------------------------
module csr_counter64 #(
  parameter int HALF_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                inc_i,
  input  logic                wr_lo_i,
  input  logic                wr_hi_i,
  input  logic [HALF_W-1:0]   wdata_lo_i,
  input  logic [HALF_W-1:0]   wdata_hi_i,
  output logic [2*HALF_W-1:0] cnt_o
);

  logic [2*HALF_W-1:0] cnt_q;
  logic [2*HALF_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      // Both halves may land together when the two CSR write ports target
      // the low and high halves in the same cycle.
      if (wr_lo_i) cnt_d[HALF_W-1:0]        = wdata_lo_i;
      if (wr_hi_i) cnt_d[2*HALF_W-1:HALF_W] = wdata_hi_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_reg.sv
// ---------------------------------------------------------------------------
// csr_reg
// Machine-mode CSR register file for the RV32I core.
//   clk_i, rst_n_i   clock, async active-low reset
//   inst_retire_i    one instruction retires this cycle (minstret enable)
//   bus              csr_reg_if.slave: combinational read port, execute and
//                    clint write ports
//   csr_mtvec_o      stored mtvec
//   csr_mepc_o       stored mepc
//   csr_mstatus_o    stored mstatus
// Only address bits [11:0] are decoded. When both write ports hit the same
// register the clint wins; different registers both commit. The read port
// forwards same-cycle write data, but the exported registers never do, so the
// clint can derive its mstatus write from csr_mstatus_o without a loop.
// ---------------------------------------------------------------------------
module csr_reg
  import csr_reg_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int CSR_BUS_WIDTH  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      inst_retire_i,
  csr_reg_if.slave                  bus,
  output logic [DATA_BUS_WIDTH-1:0] csr_mtvec_o,
  output logic [DATA_BUS_WIDTH-1:0] csr_mepc_o,
  output logic [DATA_BUS_WIDTH-1:0] csr_mstatus_o
);

  localparam int DW = DATA_BUS_WIDTH;

  // Upper address bits are outside the CSR space and deliberately ignored.
  logic addr_hi_unused;
  assign addr_hi_unused = ^{bus.ex_csr_raddr_i[CSR_BUS_WIDTH-1:12],
                            bus.ex_csr_waddr_i[CSR_BUS_WIDTH-1:12],
                            bus.clint_csr_waddr_i[CSR_BUS_WIDTH-1:12]};

  csr_sel_e          rsel;
  csr_sel_e          ex_wsel;
  csr_sel_e          cl_wsel;
  logic [DW-1:0]     ex_wdata_m;
  logic [DW-1:0]     cl_wdata_m;

  logic [DW-1:0]     mstatus_q, mstatus_d;
  logic [DW-1:0]     mie_q, mie_d;
  logic [DW-1:0]     mtvec_q, mtvec_d;
  logic [DW-1:0]     mscratch_q, mscratch_d;
  logic [DW-1:0]     mepc_q, mepc_d;
  logic [DW-1:0]     mcause_q, mcause_d;

  logic [2*DW-1:0]   mcycle;
  logic [2*DW-1:0]   minstret;
  logic [DW-1:0]     stored_rdata;

  // A port that is not writing decodes to SEL_NONE, so every later
  // comparison against a register select already includes the enable.
  assign rsel    = csr_decode(bus.ex_csr_raddr_i[11:0]);
  assign ex_wsel = bus.ex_csr_waddr_vld_i ?
                   csr_decode(bus.ex_csr_waddr_i[11:0]) : SEL_NONE;
  assign cl_wsel = bus.clint_csr_waddr_vld_i ?
                   csr_decode(bus.clint_csr_waddr_i[11:0]) : SEL_NONE;

  // Masking once per port lets storage, counters and the read bypass all
  // share the same "as stored" value.
  assign ex_wdata_m = bus.ex_csr_wdata_i    & DW'(csr_wmask(ex_wsel));
  assign cl_wdata_m = bus.clint_csr_wdata_i & DW'(csr_wmask(cl_wsel));

  function automatic logic wr_hit(input csr_sel_e sel, input csr_sel_e cl_s,
                                  input csr_sel_e ex_s);
    return (cl_s == sel) || (ex_s == sel);
  endfunction

  function automatic logic [DW-1:0] wr_next(input csr_sel_e sel,
                                            input csr_sel_e cl_s,
                                            input csr_sel_e ex_s,
                                            input logic [DW-1:0] cl_d,
                                            input logic [DW-1:0] ex_d,
                                            input logic [DW-1:0] cur);
    if (cl_s == sel) return cl_d;
    if (ex_s == sel) return ex_d;
    return cur;
  endfunction

  always_comb begin
    mstatus_d  = wr_next(SEL_MSTATUS,  cl_wsel, ex_wsel, cl_wdata_m, ex_wdata_m, mstatus_q);
    mie_d      = wr_next(SEL_MIE,      cl_wsel, ex_wsel, cl_wdata_m, ex_wdata_m, mie_q);
    mtvec_d    = wr_next(SEL_MTVEC,    cl_wsel, ex_wsel, cl_wdata_m, ex_wdata_m, mtvec_q);
    mscratch_d = wr_next(SEL_MSCRATCH, cl_wsel, ex_wsel, cl_wdata_m, ex_wdata_m, mscratch_q);
    mepc_d     = wr_next(SEL_MEPC,     cl_wsel, ex_wsel, cl_wdata_m, ex_wdata_m, mepc_q);
    mcause_d   = wr_next(SEL_MCAUSE,   cl_wsel, ex_wsel, cl_wdata_m, ex_wdata_m, mcause_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  csr_counter64 #(.HALF_W(DW)) u_mcycle (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .inc_i      (1'b1),
    .wr_lo_i    (wr_hit(SEL_MCYCLE,  cl_wsel, ex_wsel)),
    .wr_hi_i    (wr_hit(SEL_MCYCLEH, cl_wsel, ex_wsel)),
    .wdata_lo_i (wr_next(SEL_MCYCLE,  cl_wsel, ex_wsel, cl_wdata_m, ex_wdata_m, '0)),
    .wdata_hi_i (wr_next(SEL_MCYCLEH, cl_wsel, ex_wsel, cl_wdata_m, ex_wdata_m, '0)),
    .cnt_o      (mcycle)
  );

  csr_counter64 #(.HALF_W(DW)) u_minstret (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .inc_i      (inst_retire_i),
    .wr_lo_i    (wr_hit(SEL_MINSTRET,  cl_wsel, ex_wsel)),
    .wr_hi_i    (wr_hit(SEL_MINSTRETH, cl_wsel, ex_wsel)),
    .wdata_lo_i (wr_next(SEL_MINSTRET,  cl_wsel, ex_wsel, cl_wdata_m, ex_wdata_m, '0)),
    .wdata_hi_i (wr_next(SEL_MINSTRETH, cl_wsel, ex_wsel, cl_wdata_m, ex_wdata_m, '0)),
    .cnt_o      (minstret)
  );

  always_comb begin
    stored_rdata = '0;
    case (rsel)
      SEL_MSTATUS:                 stored_rdata = mstatus_q;
      SEL_MISA:                    stored_rdata = DW'(CSR_MISA_VAL);
      SEL_MIE:                     stored_rdata = mie_q;
      SEL_MTVEC:                   stored_rdata = mtvec_q;
      SEL_MSCRATCH:                stored_rdata = mscratch_q;
      SEL_MEPC:                    stored_rdata = mepc_q;
      SEL_MCAUSE:                  stored_rdata = mcause_q;
      SEL_MCYCLE,   SEL_CYCLE:     stored_rdata = mcycle[DW-1:0];
      SEL_MCYCLEH,  SEL_CYCLEH:    stored_rdata = mcycle[2*DW-1:DW];
      SEL_MINSTRET, SEL_INSTRET:   stored_rdata = minstret[DW-1:0];
      SEL_MINSTRETH, SEL_INSTRETH: stored_rdata = minstret[2*DW-1:DW];
      default:                     stored_rdata = '0;
    endcase
  end

  // Forward only writes that will actually be stored; a write to a read-only
  // or unmapped address must not show up on the read port.
  always_comb begin
    bus.ex_csr_rdata_o = stored_rdata;
    if (csr_writable(rsel)) begin
      if (cl_wsel == rsel)      bus.ex_csr_rdata_o = cl_wdata_m;
      else if (ex_wsel == rsel) bus.ex_csr_rdata_o = ex_wdata_m;
    end
  end

  assign csr_mtvec_o   = mtvec_q;
  assign csr_mepc_o    = mepc_q;
  assign csr_mstatus_o = mstatus_q;

endmodule
